// File: rtl/apb_pkg.sv
// Shared types and address-map constants for the APB initiator.
package apb_pkg;

  // Bus phase of the initiator.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // Responder i lives at APB_BASE + i*APB_SLV_SIZE.
  localparam logic [31:0] APB_BASE     = 32'h1000_0000;
  localparam logic [31:0] APB_SLV_SIZE = 32'h0000_1000;
  localparam int          APB_NUM_SLV  = 4;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decoder: one window per responder, one-hot select
// plus a hit flag. Addresses outside every window give sel=0, hit=0.
module apb_addr_decoder
  import apb_pkg::*;
(
  input  logic [31:0]            addr,
  output logic [APB_NUM_SLV-1:0] sel,
  output logic                   hit
);

  genvar gi;
  generate
    for (gi = 0; gi < APB_NUM_SLV; gi++) begin : g_win
      localparam logic [31:0] WIN_LO = APB_BASE + APB_SLV_SIZE * 32'(gi);
      localparam logic [31:0] WIN_HI = WIN_LO + APB_SLV_SIZE;
      // Full 32-bit compare so aliases above the map never decode.
      assign sel[gi] = (addr >= WIN_LO) && (addr < WIN_HI);
    end
  endgenerate

  assign hit = |sel;

endmodule

// File: rtl/apb_master.sv
// APB initiator: accepts single-beat CPU load/store requests, decodes them to
// one of four responders, runs SETUP/ACCESS and returns data or an error in a
// one-cycle ready pulse.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS phases that see no
// PREADY within TIMEOUT_CYC cycles (reported as err=1).
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
)(
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PENABLE,
  output logic [3:0]  PSEL,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  apb_state_t state_reg, state_next;

  logic [APB_NUM_SLV-1:0] sel_reg, sel_next;
  logic [31:0]            paddr_reg, paddr_next;
  logic [31:0]            pwdata_reg, pwdata_next;
  logic                   pwrite_reg, pwrite_next;
  logic [31:0]            rdata_reg, rdata_next;
  logic                   ready_reg, ready_next;
  logic                   err_reg, err_next;

  logic [APB_NUM_SLV-1:0] dec_sel;
  logic                   dec_hit;

  apb_addr_decoder u_dec (
    .addr (addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // Responder return path, gathered into arrays so the mux is one loop.
  logic [31:0]            prdata_arr    [APB_NUM_SLV];
  logic [31:0]            prdata_masked [APB_NUM_SLV];
  logic [APB_NUM_SLV-1:0] pready_vec;
  logic [31:0]            prdata_sel;
  logic                   pready_sel;

  assign prdata_arr[0] = PRDATA0;
  assign prdata_arr[1] = PRDATA1;
  assign prdata_arr[2] = PRDATA2;
  assign prdata_arr[3] = PRDATA3;
  assign pready_vec    = {PREADY3, PREADY2, PREADY1, PREADY0};

  genvar gi;
  generate
    for (gi = 0; gi < APB_NUM_SLV; gi++) begin : g_mask
      assign prdata_masked[gi] = sel_reg[gi] ? prdata_arr[gi] : 32'h0;
    end
  endgenerate

  // AND-OR read mux: only the latched responder contributes.
  always_comb begin
    prdata_sel = 32'h0;
    for (int i = 0; i < APB_NUM_SLV; i++) begin
      prdata_sel = prdata_sel | prdata_masked[i];
    end
  end

  // Unselected responders' PREADY are masked off here.
  assign pready_sel = |(pready_vec & sel_reg);

`ifdef APB_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  // The abort fires on the edge that would take the count to TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;

  // Stalled-ACCESS cycle counter.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) tmo_cnt_reg <= '0;
    else         tmo_cnt_reg <= tmo_cnt_next;
  end
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // State and registered outputs; reset forces IDLE so PSEL/PENABLE drop at once.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_reg  <= ST_IDLE;
      sel_reg    <= '0;
      paddr_reg  <= 32'h0;
      pwdata_reg <= 32'h0;
      pwrite_reg <= 1'b0;
      rdata_reg  <= 32'h0;
      ready_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      paddr_reg  <= paddr_next;
      pwdata_reg <= pwdata_next;
      pwrite_reg <= pwrite_next;
      rdata_reg  <= rdata_next;
      ready_reg  <= ready_next;
      err_reg    <= err_next;
    end
  end

  // Next-state and next-output logic; ready/err default low so they pulse.
  always_comb begin
    state_next  = state_reg;
    sel_next    = sel_reg;
    paddr_next  = paddr_reg;
    pwdata_next = pwdata_reg;
    pwrite_next = pwrite_reg;
    rdata_next  = rdata_reg;
    ready_next  = 1'b0;
    err_next    = 1'b0;
`ifdef APB_TIMEOUT_EN
    tmo_cnt_next = tmo_cnt_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (transfer) begin
          if (dec_hit) begin
            sel_next    = dec_sel;
            paddr_next  = addr;
            pwdata_next = wdata;
            pwrite_next = write;
            state_next  = ST_SETUP;
          end else begin
            // Decode miss never reaches the bus.
            ready_next = 1'b1;
            err_next   = 1'b1;
            rdata_next = 32'h0;
          end
        end
      end

      ST_SETUP: begin
        state_next = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
        tmo_cnt_next = '0;
`endif
      end

      ST_ACCESS: begin
        // PREADY has priority over the timeout in the same cycle.
        if (pready_sel) begin
          rdata_next = pwrite_reg ? 32'h0 : prdata_sel;
          ready_next = 1'b1;
          state_next = ST_IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_cnt_reg == CNT_LAST) begin
          rdata_next = 32'h0;
          ready_next = 1'b1;
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
`endif
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign PSEL    = (state_reg == ST_IDLE) ? '0 : sel_reg;
  assign PENABLE = (state_reg == ST_ACCESS);
  assign PADDR   = paddr_reg;
  assign PWDATA  = pwdata_reg;
  assign PWRITE  = pwrite_reg;
  assign rdata   = rdata_reg;
  assign ready   = ready_reg;
  assign err     = err_reg;

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator bridging the CPU's single-beat load/store request port onto the peripheral bus. It decodes the request address to one of four APB responders, runs the SETUP/ACCESS sequence, and waits for the selected responder's PREADY. It then returns read data, or a decode/timeout error, to the CPU in a single-cycle `ready` pulse. It sits between the multicycle core's data-memory path and the APB peripheral slaves (GPI, GPO, etc.).

## Interface
- `TIMEOUT_CYC`, 16: ACCESS cycles allowed before abort; only used with the timeout feature.
- `PCLK` in 1: bus clock; all logic on rising edge.
- `PRESET` in 1: reset, asynchronous, active-low.
- `transfer` in 1: CPU request strobe, sampled in IDLE only.
- `write` in 1: 1 = write, 0 = read.
- `addr` in 32: byte address.
- `wdata` in 32: write data.
- `rdata` out 32: read data, valid while `ready`=1.
- `ready` out 1: one-cycle completion pulse.
- `err` out 1: error flag, valid while `ready`=1.
- `PADDR` out 32, `PWRITE` out 1, `PWDATA` out 32: APB address, direction and data.
- `PENABLE` out 1: APB enable.
- `PSEL` out 4: one-hot responder select.
- `PRDATA0`..`PRDATA3` in 32 each: responder read data.
- `PREADY0`..`PREADY3` in 1 each: responder ready.

## Operation
- Address map: responder i occupies 0x1000_0000 + i·0x1000, size 0x1000, for i = 0..3.
  - Any address outside 0x1000_0000–0x1000_3FFF is a decode error.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - `transfer`=1 with a valid address: latch `addr`, `wdata`, `write` and the one-hot select, then go to SETUP.
  - `transfer`=1 with an invalid address: stay in IDLE and pulse `ready`=1, `err`=1, `rdata`=0 next cycle. No `PSEL` asserted.
- SETUP: `PSEL`=latched one-hot, `PENABLE`=0. Always exactly one cycle, then go to ACCESS.
- ACCESS: `PSEL` held, `PENABLE`=1.
  - PRDATA/PREADY are muxed from the selected responder only. The other responders' PREADY values are ignored.
  - Selected PREADY=1 at an edge: capture PRDATA into `rdata` (0 for writes), set `ready`=1 and `err`=0, go to IDLE.
- PADDR, PWRITE and PWDATA are stable from SETUP through the last ACCESS cycle. In IDLE they hold their last values.
- `transfer` asserted outside IDLE is ignored. The CPU must hold the request until `ready`.
- Back-to-back: `transfer` in the cycle `ready`=1 is accepted, since the FSM is already IDLE.

## Timing
- Reset values: state IDLE; `PSEL`=0, `PENABLE`=0, `PADDR`=0, `PWDATA`=0, `PWRITE`=0, `rdata`=0, `ready`=0, `err`=0.
- Reset mid-transfer: `PSEL` and `PENABLE` drop asynchronously. No `ready` is produced, and the transaction is lost.
- Latency with a zero-wait registered-PREADY responder: `transfer` sampled at edge 0 → SETUP in cycle 1 → ACCESS in cycles 2–3 → `ready` high in cycle 4.
  - Each responder wait state adds one cycle.
- `ready` and `err` are registered and last exactly one cycle.
- Decode error: `ready` is high in the cycle after `transfer` is sampled.

## Configuration
- `APB_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle without PREADY.
  - When the count reaches `TIMEOUT_CYC`, drop `PSEL`/`PENABLE`, go to IDLE, and pulse `ready`=1, `err`=1, `rdata`=0.
  - PREADY arriving in the same cycle the limit is reached wins: normal completion with `err`=0.
- `APB_TIMEOUT_EN` undefined: no counter; ACCESS waits indefinitely. `err` is set only by decode errors.

## Structure
- Package `apb_pkg`:
  - State enum typedef (IDLE/SETUP/ACCESS).
  - `APB_BASE`=32'h1000_0000, `APB_SLV_SIZE`=32'h1000, `APB_NUM_SLV`=4.
- Sub-module `apb_addr_decoder`: combinational; maps `addr` to a 4-bit one-hot select plus a `hit` flag.
- FSM, read mux and timeout counter stay in `apb_master`.

## Test plan
- Write 0x0000_00A5 to 0x1000_1000, responder 1 zero-wait:
  - `PSEL`=0010 with `PENABLE`=0 for one cycle, then `PENABLE`=1.
  - `PWDATA`=0xA5 stable throughout.
  - `ready` in cycle 4, `err`=0.
- Read 0x1000_2004 with `PRDATA2`=0x0000_00C3 and one wait state: `ready` in cycle 5, `rdata`=0xC3, `err`=0.
- Two back-to-back reads to responders 0 and 3: the second `transfer` is accepted on the `ready` cycle. `PSEL` goes 0001, then 0000 for one cycle, then 1000. Both return correct data.
- Access to 0x2000_0000: `PSEL` stays 0. Next cycle `ready`=1, `err`=1, `rdata`=0.
- With `APB_TIMEOUT_EN`, PREADY0 held 0: after 16 ACCESS cycles, `PSEL`/`PENABLE` drop and `ready`=1 with `err`=1. Without the macro, the bus stays in ACCESS.
- `PRESET` low during ACCESS: `PSEL` and `PENABLE` are 0 immediately. After release, the block is IDLE with `ready`=0, and a fresh read completes normally.
